run_ctrl: RTL and testbench

Run sequencer for the 9-bit-instruction core. It accepts a start request and holds the core in reset for a fixed number of cycles. It then releases the core to execute from a latched start address and stops it on the halt instruction. Finally it reports done and holds that state until the requester acknowledges. Sits between the top-level req/done pins and the core's PC, register file and data-memory write enables.

---
 rtl/run_ctrl_pkg.sv | 11 +
 rtl/run_ctrl_if.sv | 28 ++
 rtl/run_ctrl_sat_counter.sv | 16 +
 rtl/run_ctrl.sv | 104 ++++++++++
 tb/tb_run_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the run sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} run_state_t;

    localparam int D_DEF          = 12;
    localparam int CW_DEF         = 16;
    localparam int RST_CYCLES_DEF = 2;
    localparam int MAX_CYCLES_DEF = 4000;

endpackage

// File: rtl/run_ctrl_if.sv
// Requester handshake plus core control bundle for run_ctrl.
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int CW = CW_DEF
);
    logic          req;
    logic          halt;
    logic [D-1:0]  start_addr;
    logic          core_reset;
    logic          core_en;
    logic [D-1:0]  pc_init;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;
    logic          timeout;

    modport master (
        output req, halt, start_addr,
        input  core_reset, core_en, pc_init, busy, done, cycle_count, timeout
    );

    modport slave (
        input  req, halt, start_addr,
        output core_reset, core_en, pc_init, busy, done, cycle_count, timeout
    );
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + W'(1);
    end
endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: IDLE -> INIT (core held in reset) -> RUN -> DONE (until req drops).
// Optional watchdog on RUN length compiled in with RUN_CTRL_WATCHDOG_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int D          = D_DEF,
    parameter int CW         = CW_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    run_ctrl_if.slave  bus
);
    localparam int IW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("run_ctrl: RST_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max_cycles
        $error("run_ctrl: MAX_CYCLES must be >= 1");
    end

    run_state_t    state, state_nxt;
    logic [IW-1:0] init_cnt;
    logic [D-1:0]  pc_init_q;
    logic [CW-1:0] cycle_count;
    logic          accept;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic          wd_hit;
    logic          timeout_q;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
        wd_hit    = 1'b0;
`endif
        case (state)
            IDLE: if (bus.req) begin
                accept    = 1'b1;
                state_nxt = INIT;
            end
            INIT: if (init_cnt == '0) state_nxt = RUN;
            RUN: begin
                // halt takes priority over the watchdog on the same cycle
                if (bus.halt)
                    state_nxt = DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
                else if (cycle_count == CW'(MAX_CYCLES - 1)) begin
                    wd_hit    = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: if (!bus.req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            init_cnt  <= '0;
            pc_init_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                init_cnt  <= IW'(RST_CYCLES - 1);
                pc_init_q <= bus.start_addr;
            end else if ((state == INIT) && (init_cnt != '0)) begin
                init_cnt <= init_cnt - IW'(1);
            end
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset || accept)
            timeout_q <= 1'b0;
        else if (wd_hit)
            timeout_q <= 1'b1;
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // The halt cycle is counted; a watchdog stop lands on exactly MAX_CYCLES.
    sat_counter #(.W(CW)) u_cycle_cnt (
        .clk   (clk),
        .clr   (reset | accept),
        .en    (state == RUN),
        .count (cycle_count)
    );

    assign bus.core_reset  = (state == IDLE) || (state == INIT);
    assign bus.core_en     = (state == RUN) && !bus.halt;
    assign bus.busy        = (state == INIT) || (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.pc_init     = pc_init_q;
    assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_run_ctrl.sv
// Directed and randomized runs of run_ctrl checked against a run-level model.
module tb_run_ctrl;
    localparam int RST = 2;
    localparam int MAX = 8;
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        halt = 1'b0;
    logic [11:0] start_addr = '0;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    run_ctrl_if #(.D(12), .CW(16)) bus ();
    run_ctrl_if #(.D(12), .CW(4))  sbus ();

    assign bus.req         = req;
    assign bus.halt        = halt;
    assign bus.start_addr  = start_addr;
    assign sbus.req        = req;
    assign sbus.halt       = halt;
    assign sbus.start_addr = start_addr;

    run_ctrl #(.D(12), .CW(16), .RST_CYCLES(RST), .MAX_CYCLES(MAX)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    run_ctrl #(.D(12), .CW(4), .RST_CYCLES(RST), .MAX_CYCLES(MAX)) dut_s (
        .clk(clk), .reset(reset), .bus(sbus.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input logic [11:0] pc, input int cc,
                              input int cc_s, input bit to);
        #1;
        check({tag, ".core_reset"}, 32'(bus.core_reset), 1);
        check({tag, ".core_en"},    32'(bus.core_en), 0);
        check({tag, ".busy"},       32'(bus.busy), 0);
        check({tag, ".done"},       32'(bus.done), 0);
        check({tag, ".pc_init"},    32'(bus.pc_init), 32'(pc));
        check({tag, ".cycle_count"}, 32'(bus.cycle_count), 32'(cc));
        check({tag, ".small_count"}, 32'(sbus.cycle_count), 32'(cc_s));
        check({tag, ".timeout"},    32'(bus.timeout), 32'(to));
    endtask

    // One full run from IDLE. halt_at: RUN cycle carrying halt (0 = never);
    // drop_at: RUN cycle on which req falls (0 = held); rst_at: RUN cycle with reset.
    task automatic do_run(input string tag, input logic [11:0] addr, input int halt_at,
                          input int drop_at, input int rst_at, input int hold);
        int len;
        bit to;
        int exp_cc;
        int exp_cc_s;
        if (WD && (halt_at == 0 || halt_at > MAX)) begin
            len = MAX;
            to  = 1'b1;
        end else begin
            len = halt_at;
            to  = 1'b0;
        end
        exp_cc   = (len > 65535) ? 65535 : len;
        exp_cc_s = (len > 15) ? 15 : len;

        start_addr = addr;
        req  = 1'b1;
        halt = 1'b0;
        step();
        #1;
        check({tag, ".latched_pc"}, 32'(bus.pc_init), 32'(addr));
        check({tag, ".cleared_cc"}, 32'(bus.cycle_count), 0);
        check({tag, ".cleared_to"}, 32'(bus.timeout), 0);
        start_addr = 12'($urandom);
        for (int i = 1; i <= RST; i++) begin
            halt = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("%s.init%0d.core_reset", tag, i), 32'(bus.core_reset), 1);
            check($sformatf("%s.init%0d.busy", tag, i), 32'(bus.busy), 1);
            check($sformatf("%s.init%0d.core_en", tag, i), 32'(bus.core_en), 0);
            check($sformatf("%s.init%0d.done", tag, i), 32'(bus.done), 0);
            step();
        end
        for (int n = 1; n <= len; n++) begin
            halt = (n == halt_at);
            if (n == drop_at) req = 1'b0;
            if (n == rst_at) reset = 1'b1;
            #1;
            check($sformatf("%s.run%0d.core_reset", tag, n), 32'(bus.core_reset), 0);
            check($sformatf("%s.run%0d.busy", tag, n), 32'(bus.busy), 1);
            check($sformatf("%s.run%0d.done", tag, n), 32'(bus.done), 0);
            check($sformatf("%s.run%0d.core_en", tag, n), 32'(bus.core_en), 32'(!halt));
            step();
            if (n == rst_at) break;
        end
        halt = 1'b0;
        if (rst_at != 0) begin
            req = 1'b0;
            check_idle({tag, ".after_reset"}, 12'h000, 0, 0, 1'b0);
            reset = 1'b0;
            return;
        end
        #1;
        check({tag, ".done"},        32'(bus.done), 1);
        check({tag, ".busy"},        32'(bus.busy), 0);
        check({tag, ".core_reset"},  32'(bus.core_reset), 0);
        check({tag, ".core_en"},     32'(bus.core_en), 0);
        check({tag, ".cycle_count"}, 32'(bus.cycle_count), 32'(exp_cc));
        check({tag, ".small_count"}, 32'(sbus.cycle_count), 32'(exp_cc_s));
        check({tag, ".timeout"},     32'(bus.timeout), 32'(to));
        if (req) begin
            for (int h = 0; h < hold; h++) begin
                step();
                #1;
                check({tag, ".done_held"}, 32'(bus.done), 1);
            end
            req = 1'b0;
        end
        step();
        check_idle({tag, ".idle"}, addr, exp_cc, exp_cc_s, to);
    endtask

    initial begin
        step();
        step();
        check_idle("reset", 12'h000, 0, 0, 1'b0);
        reset = 1'b0;

        halt = 1'b1;
        step();
        check_idle("idle_halt", 12'h000, 0, 0, 1'b0);
        halt = 1'b0;

        do_run("basic",     12'h010, 5, 0, 0, 2);
        do_run("rerun",     12'h3A5, 3, 0, 0, 1);
        do_run("req_drop",  12'h0F0, 4, 2, 0, 0);
        do_run("mid_reset", 12'h777, 6, 0, 3, 0);
        do_run("post_rst",  12'h123, 2, 0, 0, 0);
        if (WD) begin
            do_run("wd_nohalt",  12'h100, 0, 0, 0, 1);
            do_run("wd_tie",     12'h101, MAX, 0, 0, 0);
            do_run("wd_early",   12'h102, MAX - 1, 0, 0, 0);
            do_run("wd_late",    12'h103, MAX + 3, 0, 0, 0);
        end else begin
            do_run("sat_small",  12'h200, 20, 0, 0, 0);
            do_run("sat_edge",   12'h201, 15, 0, 0, 1);
            do_run("long_run",   12'h202, 300, 0, 0, 0);
        end

        for (int r = 0; r < 8; r++) begin
            int h;
            h = WD ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 40));
            do_run($sformatf("rand%0d", r), 12'($urandom), h,
                   int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
